dlx_mem_ctrl: RTL and testbench

//   Memory-access sequencer between the DLX control unit and external memory,

---
 rtl/dlx_mem_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_dlx_mem_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/dlx_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : dlx_mem_ctrl
// Purpose  : Memory-access sequencer between the DLX control unit and external
//            memory, upstream of the MDR. Runs one load or store handshake with
//            wait-state support and an alignment/size check. Loads are lane-
//            extracted (big-endian) and sign/zero-extended onto load_data with
//            a one-cycle mdr_load pulse. Stores raise mem_we, which also gates
//            the MDR onto the data bus.
// Ports    : clk, reset (async, active-high)
//            req_rd, req_wr, size, sign_ext, addr   - request from control unit
//            mem_rdata, mem_ready                   - memory response
//            mem_addr, mem_re, mem_we, mem_be       - memory command
//            load_data, mdr_load                    - MDR load path
//            busy, done, bus_err                    - status
// Revision : 1.0 - initial release
// ============================================================================
module dlx_mem_ctrl #(
  parameter int WAIT_MAX = 16,
  parameter int WAIT_W   = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic        mem_re,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] load_data,
  output logic        mdr_load,
  output logic        busy,
  output logic        done,
  output logic        bus_err
);

  localparam logic [1:0] C_IDLE   = 2'd0;
  localparam logic [1:0] C_ACCESS = 2'd1;
  localparam logic [1:0] C_DONE   = 2'd2;
  localparam logic [1:0] C_ERR    = 2'd3;

  localparam logic [WAIT_W-1:0] C_WAIT_LAST = WAIT_W'(WAIT_MAX - 1);

  logic [1:0]        r_state;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic              r_sign;
  logic              r_is_load;

  logic              w_legal;
  logic [3:0]        w_be;
  logic [7:0]        w_byte;
  logic [15:0]       w_half;
  logic [31:0]       w_fmt;

  // Request decode from the live inputs, used only in IDLE.
  always_comb begin
    w_legal = 1'b0;
    w_be    = 4'b1111;
    case (size)
      2'b00: begin
        w_legal = 1'b1;
        w_be    = 4'b1000 >> addr[1:0];
      end
      2'b01: begin
        w_legal = ~addr[0];
        w_be    = addr[1] ? 4'b0011 : 4'b1100;
      end
      2'b10: begin
        w_legal = (addr[1:0] == 2'b00);
        w_be    = 4'b1111;
      end
      default: begin
        w_legal = 1'b0;
        w_be    = 4'b1111;
      end
    endcase
  end

  // Load formatting from the latched offset/size: big-endian, offset 0 is
  // the most significant lane.
  always_comb begin
    case (r_off)
      2'd0:    w_byte = mem_rdata[31:24];
      2'd1:    w_byte = mem_rdata[23:16];
      2'd2:    w_byte = mem_rdata[15:8];
      default: w_byte = mem_rdata[7:0];
    endcase
    w_half = r_off[1] ? mem_rdata[15:0] : mem_rdata[31:16];
    case (r_size)
      2'b00:   w_fmt = {{24{r_sign & w_byte[7]}}, w_byte};
      2'b01:   w_fmt = {{16{r_sign & w_half[15]}}, w_half};
      default: w_fmt = mem_rdata;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= C_IDLE;
      r_wait_cnt <= '0;
      r_size     <= 2'b00;
      r_off      <= 2'b00;
      r_sign     <= 1'b0;
      r_is_load  <= 1'b0;
      mem_addr   <= 32'd0;
      mem_re     <= 1'b0;
      mem_we     <= 1'b0;
      mem_be     <= 4'b0000;
      load_data  <= 32'd0;
      mdr_load   <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      bus_err    <= 1'b0;
    end else begin
      // Pulses default low; set only on entry to DONE/ERR.
      done     <= 1'b0;
      mdr_load <= 1'b0;
      bus_err  <= 1'b0;
      case (r_state)
        C_IDLE: begin
          r_wait_cnt <= '0;
          if (req_rd ^ req_wr) begin
            r_size    <= size;
            r_off     <= addr[1:0];
            r_sign    <= sign_ext;
            r_is_load <= req_rd;
            mem_addr  <= {addr[31:2], 2'b00};
            busy      <= 1'b1;
            if (w_legal) begin
              r_state <= C_ACCESS;
              mem_re  <= req_rd;
              mem_we  <= req_wr;
              mem_be  <= w_be;
            end else begin
              r_state <= C_ERR;
              bus_err <= 1'b1;
            end
          end else if (req_rd && req_wr) begin
            r_state <= C_ERR;
            busy    <= 1'b1;
            bus_err <= 1'b1;
          end
        end
        C_ACCESS: begin
          if (mem_ready) begin
            r_state  <= C_DONE;
            mem_re   <= 1'b0;
            mem_we   <= 1'b0;
            mem_be   <= 4'b0000;
            done     <= 1'b1;
            mdr_load <= r_is_load;
            if (r_is_load) begin
              load_data <= w_fmt;
            end
          end else if (r_wait_cnt == C_WAIT_LAST) begin
            r_state <= C_ERR;
            mem_re  <= 1'b0;
            mem_we  <= 1'b0;
            mem_be  <= 4'b0000;
            bus_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
          end
        end
        default: begin
          // DONE and ERR last exactly one cycle; requests are not sampled.
          r_state <= C_IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dlx_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_dlx_mem_ctrl
// Purpose  : Self-checking bench for dlx_mem_ctrl. A transaction-level model
//            derives the expected per-cycle outputs from each request; a
//            single negedge process compares them against the DUT.
// Revision : 1.0 - initial release
// ============================================================================
module tb_dlx_mem_ctrl;

  localparam int WAIT_MAX = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_rd, req_wr;
  logic [1:0]  size;
  logic        sign_ext;
  logic [31:0] addr;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic        mem_re, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] load_data;
  logic        mdr_load, busy, done, bus_err;

  dlx_mem_ctrl #(.WAIT_MAX(WAIT_MAX), .WAIT_W(5)) dut (
    .clk(clk), .reset(reset), .req_rd(req_rd), .req_wr(req_wr), .size(size),
    .sign_ext(sign_ext), .addr(addr), .mem_rdata(mem_rdata),
    .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_re(mem_re),
    .mem_we(mem_we), .mem_be(mem_be), .load_data(load_data),
    .mdr_load(mdr_load), .busy(busy), .done(done), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Expected outputs for the current cycle.
  logic        chk_en = 1'b0;
  logic        exp_busy, exp_re, exp_we, exp_done, exp_mdr, exp_err, exp_acc;
  logic [31:0] exp_ld, exp_addr;
  logic [3:0]  exp_be;
  logic [31:0] model_ld = 32'd0;
  logic [3:0]  first_be;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, want, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("mem_re", 32'(mem_re), 32'(exp_re));
      chk("mem_we", 32'(mem_we), 32'(exp_we));
      chk("done", 32'(done), 32'(exp_done));
      chk("mdr_load", 32'(mdr_load), 32'(exp_mdr));
      chk("bus_err", 32'(bus_err), 32'(exp_err));
      chk("load_data", load_data, exp_ld);
      if (exp_acc) begin
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", 32'(mem_be), 32'(exp_be));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_exp(input logic b, input logic re, input logic we,
                         input logic dn, input logic md, input logic er, input logic acc);
    exp_busy = b; exp_re = re; exp_we = we; exp_done = dn;
    exp_mdr = md; exp_err = er; exp_acc = acc; exp_ld = model_ld;
  endtask

  task automatic set_idle();
    req_rd = 1'b0; req_wr = 1'b0; mem_ready = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0, 0);
  endtask

  // Spec-level load formatting: big-endian lane pick plus extension.
  function automatic logic [31:0] fmt_model(input logic [1:0] sz, input logic sx,
                                            input logic [1:0] off, input logic [31:0] d);
    logic [31:0] v;
    if (sz == 2'd0) begin
      v = (d >> (8 * (3 - int'(off)))) & 32'hFF;
      if (sx && v[7]) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = (d >> (16 * (1 - int'(off) / 2))) & 32'hFFFF;
      if (sx && v[15]) v = v | 32'hFFFF_0000;
    end else begin
      v = d;
    end
    return v;
  endfunction

  function automatic logic [3:0] be_model(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'b1000 >> off;
    if (sz == 2'd1) return (off == 2'd0) ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  // One complete transaction starting in an IDLE cycle (at posedge+1).
  // waits >= WAIT_MAX means memory never answers.
  task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sx, input logic [31:0] a, input int waits,
                        input logic [31:0] rdata);
    logic bad;
    req_rd = rd; req_wr = wr; size = sz; sign_ext = sx; addr = a;
    mem_ready = 1'b0;
    bad = (rd && wr) || (sz == 2'd3) || (sz == 2'd1 && a[0]) ||
          (sz == 2'd2 && a[1:0] != 2'd0);
    step();
    if (bad) begin
      req_rd = 1'b0; req_wr = 1'b0;
      set_exp(1, 0, 0, 0, 0, 1, 0);
      step();
      set_idle();
      return;
    end
    for (int i = 0; i < WAIT_MAX; i++) begin
      set_exp(1, rd, wr, 0, 0, 0, 1);
      exp_addr = {a[31:2], 2'b00};
      exp_be   = be_model(sz, a[1:0]);
      if (i == 0) first_be = mem_be;
      mem_ready = (i == waits);
      mem_rdata = (i == waits) ? rdata : $urandom;
      step();
      if (i == waits) begin
        // DONE cycle: requests here are junk and must be ignored.
        if (rd) model_ld = fmt_model(sz, sx, a[1:0], rdata);
        req_rd = 1'($urandom); req_wr = 1'($urandom); addr = $urandom;
        size = 2'($urandom); mem_ready = 1'($urandom);
        set_exp(1, 0, 0, 1, rd, 0, 0);
        step();
        set_idle();
        return;
      end
    end
    // Timeout.
    req_rd = 1'b0; req_wr = 1'b0; mem_ready = 1'b0;
    set_exp(1, 0, 0, 0, 0, 1, 0);
    step();
    set_idle();
  endtask

  initial begin
    logic [1:0] rsz;
    logic [31:0] ra;
    int rw, rsel;
    reset = 1'b1;
    req_rd = 0; req_wr = 0; size = 0; sign_ext = 0; addr = 0;
    mem_rdata = 0; mem_ready = 0; first_be = 0;
    set_idle();
    chk_en = 1'b1;
    step();
    step();
    reset = 1'b0;
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_mem_be", 32'(mem_be), 32'd0);
    step();

    // 1: word load, zero wait
    do_txn(1, 0, 2'd2, 0, 32'h100, 0, 32'hDEADBEEF);
    chk("t1_load_data", load_data, 32'hDEADBEEF);
    chk("t1_be", 32'(first_be), 32'hF);
    // 2: byte load at offset 3, signed and unsigned
    do_txn(1, 0, 2'd0, 1, 32'h103, 0, 32'h000000F0);
    chk("t2_sext", load_data, 32'hFFFFFFF0);
    chk("t2_be", 32'(first_be), 32'h1);
    do_txn(1, 0, 2'd0, 0, 32'h103, 1, 32'h000000F0);
    chk("t2_zext", load_data, 32'h000000F0);
    // 3: half store, 3 wait states
    do_txn(0, 1, 2'd1, 0, 32'h202, 3, 32'h0);
    chk("t3_be", 32'(first_be), 32'h3);
    chk("t3_ld_kept", load_data, 32'h000000F0);
    // 4: misaligned word, both requests
    do_txn(1, 0, 2'd2, 0, 32'h102, 0, 32'h0);
    do_txn(1, 1, 2'd2, 0, 32'h100, 0, 32'h0);
    // 5: timeout, and ready on the very last allowed cycle
    do_txn(1, 0, 2'd2, 0, 32'h300, WAIT_MAX, 32'h0);
    do_txn(1, 0, 2'd1, 1, 32'h302, WAIT_MAX - 1, 32'h1234_8001);
    chk("t5_half", load_data, 32'hFFFF8001);

    // 6: reset mid-ACCESS
    req_rd = 1; req_wr = 0; size = 2'd2; addr = 32'h400; mem_ready = 0;
    step();
    set_exp(1, 1, 0, 0, 0, 0, 1);
    exp_addr = 32'h400; exp_be = 4'hF;
    step();
    #2;
    reset = 1'b1;
    model_ld = 32'd0;
    set_idle();
    #1;
    chk("t6_busy", 32'(busy), 32'd0);
    chk("t6_re", 32'(mem_re), 32'd0);
    chk("t6_addr", mem_addr, 32'd0);
    chk("t6_ld", load_data, 32'd0);
    chk("t6_be", 32'(mem_be), 32'd0);
    step();
    reset = 1'b0;
    step();
    do_txn(1, 0, 2'd1, 0, 32'h406, 2, 32'hCAFE_9876);
    chk("t6_after", load_data, 32'h00009876);

    // Randomized traffic
    for (int n = 0; n < 250; n++) begin
      rsel = $urandom_range(0, 19);
      rsz  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      ra   = $urandom;
      if ($urandom_range(0, 3) != 0) begin
        if (rsz == 2'd2) ra[1:0] = 2'd0;
        if (rsz == 2'd1) ra[0] = 1'b0;
      end
      rw = $urandom_range(0, 9);
      if (rw == 9) rw = ($urandom_range(0, 1) == 1) ? WAIT_MAX : WAIT_MAX - 1;
      else if (rw > 4) rw = 0;
      do_txn(rsel == 0 ? 1'b1 : rsel < 10, rsel == 0 ? 1'b1 : rsel >= 10,
             rsz, 1'($urandom), ra, rw, $urandom);
      for (int g = $urandom_range(0, 2); g > 0; g--) step();
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
